instr_fetch_queue: RTL and testbench

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/instr_fetch_queue.sv | 190 +++++++++++++++++++
 tb/tb_instr_fetch_queue.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues one word read at a time to instruction
// memory, buffers {pc, instr} pairs in a small FIFO for decode, and handles
// PC redirects by flushing the queue and dropping any response in flight.
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    redirect_i,
  input  logic [31:0]             redirect_pc_i,
  output logic                    mem_req_o,
  output logic [31:0]             mem_addr_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [31:0]             mem_rdata_i,
  output logic                    instr_valid_o,
  output logic [31:0]             instr_o,
  output logic [31:0]             pc_o,
  input  logic                    instr_ready_i,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int unsigned   AW      = $clog2(DEPTH);
  localparam int unsigned   CW      = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic          drop_q, drop_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]   fifo_pc_q    [DEPTH];
  logic [31:0]   fifo_instr_q [DEPTH];

  logic          push_s;
  logic          pop_s;
  logic          head_valid_s;
  logic [31:0]   redirect_pc_s;
  logic          unused_pc_lsb_s;

  // Word-align the redirect target; the low two bits carry no meaning.
  assign redirect_pc_s   = {redirect_pc_i[31:2], 2'b00};
  assign unused_pc_lsb_s = ^redirect_pc_i[1:0];

  assign head_valid_s = (count_q != {CW{1'b0}});

  // A redirect wins over both queue ports: the flush discards same-cycle traffic.
  assign pop_s  = head_valid_s & instr_ready_i & ~redirect_i;
  assign push_s = (state_q == ST_WAIT) & mem_rvalid_i & ~drop_q & ~redirect_i;

  // Queue pointers and occupancy for the coming cycle, including flush.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (redirect_i) begin
      count_d  = {CW{1'b0}};
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Fetch FSM: next state, fetch PC, latched request address and drop flag.
  // The single outstanding request is the credit, so IDLE only leaves when
  // the queue has room and WAIT only re-requests if room remains after push.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    drop_d     = drop_q;
    case (state_q)
      ST_IDLE: begin
        if (redirect_i) begin
          fetch_pc_d = redirect_pc_s;
        end else if (start_i && (count_q < DEPTH_C)) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_gnt_i) begin
          state_d    = ST_WAIT;
          req_addr_d = fetch_pc_q;
          if (redirect_i) begin
            fetch_pc_d = redirect_pc_s;
            drop_d     = 1'b1;
          end else begin
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end else if (redirect_i) begin
          fetch_pc_d = redirect_pc_s;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid_i) begin
          // A response arriving with a redirect is discarded by the flush,
          // so the drop flag must not outlive this cycle.
          drop_d = 1'b0;
          if (redirect_i) begin
            fetch_pc_d = redirect_pc_s;
          end else begin
            fetch_pc_d = fetch_pc_q;
          end
          if (start_i && (count_d < DEPTH_C)) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (redirect_i) begin
          fetch_pc_d = redirect_pc_s;
          drop_d     = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state registers; reset abandons any request in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= 32'h0000_0000;
      drop_q     <= 1'b0;
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Queue storage; contents are only observed through a valid head.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      fifo_pc_q[wr_ptr_q]    <= req_addr_q;
      fifo_instr_q[wr_ptr_q] <= mem_rdata_i;
    end
  end

  assign mem_req_o     = (state_q == ST_REQ);
  assign mem_addr_o    = fetch_pc_q;
  assign instr_valid_o = head_valid_s;
  assign instr_o       = head_valid_s ? fifo_instr_q[rd_ptr_q] : 32'h0000_0000;
  assign pc_o          = head_valid_s ? fifo_pc_q[rd_ptr_q]    : 32'h0000_0000;
  assign count_o       = count_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a simple responding memory.
module tb_instr_fetch_queue;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_ready_i;
  logic [2:0]  count_o;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_req;
  int          npop  = 0;
  int          nreq  = 0;
  int          rsp_delay = 0;

  // responder state
  logic        busy  = 1'b0;
  int          cnt   = 0;
  logic [31:0] gaddr = 32'h0;
  logic [31:0] gaddr_n = 32'h0;

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .instr_ready_i (instr_ready_i),
    .count_o       (count_o)
  );

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Check head/request for the current cycle, then advance one clock.
  task automatic step();
    if (instr_valid_o && instr_ready_i) begin
      chk("head_pc", pc_o, exp_pc);
      chk("head_instr", instr_o, mem_data(exp_pc));
      exp_pc = exp_pc + 32'd4;
      npop++;
    end
    if (mem_req_o) begin
      chk("req_addr", mem_addr_o, exp_req);
      exp_req = exp_req + 32'd4;
      nreq++;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    start_i = 1'b0;
    instr_ready_i = 1'b0;
    redirect_i = 1'b0;
    repeat (6) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    exp_pc = 32'h0;
    exp_req = 32'h0;
  endtask

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Memory: grants any request at once, answers rsp_delay cycles after grant.
  initial begin
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i = 32'h0;
    forever begin
      @(negedge clk_i);
      mem_rvalid_i = 1'b0;
      if (mem_gnt_i) begin
        busy = 1'b1;
        cnt = rsp_delay;
        gaddr = gaddr_n;
      end
      if (busy) begin
        if (cnt == 0) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i = mem_data(gaddr);
          busy = 1'b0;
        end else begin
          cnt--;
        end
      end
      mem_gnt_i = mem_req_o;
      gaddr_n = mem_addr_o;
    end
  end

  initial begin
    int p0;
    int r0;
    logic seen;
    rst_i = 1'b0;
    start_i = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = 32'h0;
    instr_ready_i = 1'b0;
    exp_pc = 32'h0;
    exp_req = 32'h0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rst_count", {29'd0, count_o}, 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    rst_i = 1'b1;

    // streaming with immediate grant, data one cycle later, decode always ready
    rsp_delay = 0;
    start_i = 1'b1;
    instr_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) step();
    chk("p1_pops", (npop >= 6) ? 32'd1 : 32'd0, 32'd1);

    // decode stalled: queue fills to 4 and requests stop
    instr_ready_i = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("p2_count", {29'd0, count_o}, 32'd4);
    chk("p2_valid", {31'd0, instr_valid_o}, 32'd1);
    chk("p2_head", pc_o, exp_pc);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seen = seen | mem_req_o;
      step();
    end
    chk("p2_noreq", {31'd0, seen}, 32'd0);
    r0 = nreq;
    instr_ready_i = 1'b1;
    step();
    instr_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("p2_onereq", 32'(nreq - r0), 32'd1);
    chk("p2_refull", {29'd0, count_o}, 32'd4);

    // redirect while waiting on a response
    do_reset();
    rsp_delay = 3;
    start_i = 1'b1;
    for (int i = 0; i < 40 && !(count_o == 3'd1 && mem_req_o); i++) step();
    chk("p3_fill", {31'd0, (count_o == 3'd1 && mem_req_o)}, 32'd1);
    step();
    chk("p3_wait", {31'd0, mem_req_o}, 32'd0);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0103;
    step();
    redirect_i = 1'b0;
    chk("p3_flush", {29'd0, count_o}, 32'd0);
    chk("p3_valid", {31'd0, instr_valid_o}, 32'd0);
    exp_pc = 32'h0000_0100;
    exp_req = 32'h0000_0100;
    for (int i = 0; i < 12 && !mem_req_o; i++) step();
    chk("p3_addr", mem_addr_o, 32'h0000_0100);
    chk("p3_dropped", {29'd0, count_o}, 32'd0);
    p0 = npop;
    instr_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("p3_pops", (npop - p0 >= 1) ? 32'd1 : 32'd0, 32'd1);

    // redirect in the same cycle as the grant
    do_reset();
    rsp_delay = 0;
    start_i = 1'b1;
    step();
    chk("p4_req", {31'd0, mem_req_o}, 32'd1);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0200;
    step();
    redirect_i = 1'b0;
    exp_pc = 32'h0000_0200;
    exp_req = 32'h0000_0200;
    step();
    chk("p4_count", {29'd0, count_o}, 32'd0);
    chk("p4_req2", {31'd0, mem_req_o}, 32'd1);
    chk("p4_addr", mem_addr_o, 32'h0000_0200);
    p0 = npop;
    instr_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("p4_pops", (npop - p0 >= 2) ? 32'd1 : 32'd0, 32'd1);

    // address wrap at the top of memory, reached by an idle redirect
    do_reset();
    instr_ready_i = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFE;
    step();
    redirect_i = 1'b0;
    chk("p5_idle", {31'd0, mem_req_o}, 32'd0);
    chk("p5_pc", mem_addr_o, 32'hFFFF_FFFC);
    exp_pc = 32'hFFFF_FFFC;
    exp_req = 32'hFFFF_FFFC;
    start_i = 1'b1;
    p0 = npop;
    for (int i = 0; i < 8; i++) step();
    chk("p5_pops", (npop - p0 >= 2) ? 32'd1 : 32'd0, 32'd1);

    // reset during WAIT, late response after release must be ignored
    do_reset();
    rsp_delay = 2;
    start_i = 1'b1;
    step();
    step();
    chk("p6_wait", {31'd0, mem_req_o}, 32'd0);
    rst_i = 1'b0;
    start_i = 1'b0;
    #1;
    chk("p6_async", mem_addr_o, 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("p6_count", {29'd0, count_o}, 32'd0);
    chk("p6_noreq", {31'd0, mem_req_o}, 32'd0);
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("p6_restart", {31'd0, mem_req_o}, 32'd1);
    chk("p6_addr", mem_addr_o, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
